// File: rtl/mpsubtractor.sv
// Multi-precision unsigned subtractor: C = (A - B) mod 2^N plus final borrow,
// one W-bit limb per cycle, least-significant limb first.
module mpsubtractor #(
  parameter int N = 128,
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] C,
  output logic         borrow,
  output logic         busy,
  output logic         done
);

  localparam int NW = N / W;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] LAST_LIMB = CW'(NW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  // W+1-bit limb subtract; the MSB of the result is the outgoing borrow.
  function automatic logic [W:0] limb_sub(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic         bin);
    limb_sub = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
  endfunction

  state_t          state_r;
  state_t          state_nx_s;
  logic [N-1:0]    aq_r;
  logic [N-1:0]    bq_r;
  logic [N-1:0]    res_r;
  logic            brw_r;
  logic [CW-1:0]   cnt_r;
  logic            busy_r;
  logic            done_r;
  logic [W:0]      diff_s;
  logic [N+W-1:0]  res_shift_s;

  assign diff_s      = limb_sub(aq_r[W-1:0], bq_r[W-1:0], brw_r);
  // New limb enters at the MSB side; the shift also covers the NW=1 case.
  assign res_shift_s = {diff_s[W-1:0], res_r} >> W;

  assign C      = res_r;
  assign borrow = brw_r;
  assign busy   = busy_r;
  assign done   = done_r;

  // Next-state logic for the IDLE/SUB/DONE sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = SUB;
        end else begin
          state_nx_s = IDLE;
        end
      end
      SUB: begin
        if (cnt_r == LAST_LIMB) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = SUB;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State, status flags and limb datapath registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= IDLE;
      aq_r    <= {N{1'b0}};
      bq_r    <= {N{1'b0}};
      res_r   <= {N{1'b0}};
      brw_r   <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == SUB) || (state_nx_s == DONE);
      done_r  <= (state_nx_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            aq_r  <= A;
            bq_r  <= B;
            brw_r <= 1'b0;
            cnt_r <= {CW{1'b0}};
          end else begin
            aq_r  <= aq_r;
            bq_r  <= bq_r;
            brw_r <= brw_r;
            cnt_r <= cnt_r;
          end
        end
        SUB: begin
          aq_r  <= aq_r >> W;
          bq_r  <= bq_r >> W;
          res_r <= res_shift_s[N-1:0];
          brw_r <= diff_s[W];
          cnt_r <= cnt_r + CW'(1);
        end
        default: begin
          aq_r  <= aq_r;
          bq_r  <= bq_r;
          res_r <= res_r;
          brw_r <= brw_r;
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

endmodule

// File: doc/mpsubtractor.md
Name: mpsubtractor

Overview:
- Multi-precision unsigned subtractor: computes C = (A - B) mod 2^N plus a final borrow flag.
- Processes one W-bit limb per cycle, least-significant limb first, and ripples the borrow between limbs in a 1-bit register.
- Counterpart to the team's multi-precision adder.
- Used by modular-reduction and compare datapaths (e.g. conditional subtract of the modulus, A >= B test).

Parameters:
- N, 128, operand/result width in bits; must be an integer multiple of W.
- W, 64, limb width in bits, i.e. the width of the single subtract unit.

Ports:
- clk     input   1   clock
- resetn  input   1   synchronous, active-low reset
- start   input   1   request; sampled only in IDLE
- A       input   N   minuend; sampled on the accepting edge only
- B       input   N   subtrahend; sampled on the accepting edge only
- C       output  N   difference (A - B) mod 2^N; valid while done=1, then held
- borrow  output  1   1 iff A < B (unsigned); valid while done=1, then held
- busy    output  1   high in SUB and DONE states
- done    output  1   one-cycle completion pulse

Behaviour:
- Reset: resetn is synchronous and active-low, on the rising edge of clk. It applies in every state, including mid-operation.
  - State goes to IDLE; all registers clear, including operand shift registers, result register, borrow register and limb counter.
  - C=0, borrow=0, done=0, busy=0.
  - An in-flight operation is abandoned with no done pulse.
- NW = N/W limbs. Limb counter width is max(1, clog2(NW)).
- FSM states: IDLE, SUB, DONE.
- IDLE:
  - On an edge with start=1: load A and B into the operand shift registers, clear the borrow register, clear the counter, go to SUB.
  - Otherwise remain in IDLE; C and borrow hold their last values.
- SUB: each edge computes {bout, d} = {1'b0, Aq[W-1:0]} - {1'b0, Bq[W-1:0]} - bin, with all widths W+1. Then:
  - bin is the borrow register.
  - bout = 1 iff the W+1-bit result is negative, i.e. its MSB is 1.
  - Result register <= {d, result[N-1:W]} (shift right by W, new limb enters at the MSB side).
  - Aq and Bq shift right by W with zero fill.
  - Borrow register <= bout; counter increments.
  - On the edge that processes limb NW-1, go to DONE.
- DONE: done=1 for exactly one cycle. C = result register and borrow = borrow register. Next edge goes to IDLE.
- Latency: start accepted at edge k means done is high in the cycle following edge k+NW. The next start is accepted no earlier than edge k+NW+2.
- start while in SUB or DONE is ignored; nothing is queued. A held-high start restarts in the first IDLE cycle using the A/B present at that edge.
- A/B may change freely after the accepting edge without affecting the result.
- C is internal-progress data while busy=1 in SUB, and is valid only from done onward. C/borrow hold from DONE through IDLE until the next operation's SUB edges overwrite them.
- Degenerate case NW=1: a single SUB cycle, then DONE.
- done is a registered-state decode (state==DONE), glitch-free, and has no combinational path from start.

Test Plan:
- Basic subtract: N=128, W=64, A=5, B=3, start pulsed at edge k.
  -> done only in the cycle after edge k+2; C=2, borrow=0; busy high for 3 cycles.
- Cross-limb borrow: A=2^64, B=1.
  -> C=0x0000000000000000_FFFFFFFFFFFFFFFF, borrow=0.
- Underflow: A=0, B=1.
  -> C = all ones (2^128-1), borrow=1.
- Equal operands with start held high for 10 cycles: A=B=0xDEADBEEF_..._CAFEBABE.
  -> C=0 and borrow=0 for each run; starts during busy are ignored; done pulses separated by exactly 4 cycles.
- Reset mid-operation: resetn=0 on the SUB edge for limb 0 (A=7, B=9).
  -> next cycle IDLE, C=0, borrow=0, done=0, busy=0, no done pulse; a following run with A=9, B=7 gives C=2, borrow=0.
- Randomized: N=256, W=64 and N=64, W=64, 1000 random pairs including A<B, A=B and all-ones edge values; A/B scrambled after the accepting edge.
  -> C and borrow match the reference model (A-B) mod 2^N and (A<B); done latency is always NW+1.
